// File: rtl/ysyx_22040895_regfile_mp_pkg.sv
// Register file shared constants and helpers.
// Defaults for width, depth and port counts.
package ysyx_22040895_regfile_mp_pkg;
  localparam int RF_XLEN = 64;
  localparam int RF_NREG = 32;
  localparam int RF_NRD  = 2;
  localparam int RF_NWR  = 2;
  localparam int RF_BYP  = 1;

  localparam logic RST_ACT = 1'b0;
  localparam logic WR_EN   = 1'b1;
  localparam logic RD_EN   = 1'b1;
endpackage

// File: rtl/ysyx_22040895_regfile_mp_scoreboard.sv
// Busy scoreboard: flush > write-clear < alloc-set.
// In: we/waddr/alloc/flush. Out: busy vector.
module ysyx_22040895_rf_scoreboard
  import ysyx_22040895_regfile_mp_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = $clog2(NREG),
  parameter int NWR  = RF_NWR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] waddr_i,
  input  logic            alloc_i,
  input  logic [AW-1:0]   alloc_addr_i,
  input  logic            flush_i,
  output logic [NREG-1:0] busy_o
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_nxt;

  always_comb begin
    w_nxt = r_busy;
    if (flush_i) begin
      w_nxt = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we_i[j] == WR_EN)
          w_nxt[waddr_i[j*AW +: AW]] = 1'b0;
      end
      // a new producer overrides a same-cycle release
      if (alloc_i)
        w_nxt[alloc_addr_i] = 1'b1;
    end
    w_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT)
      r_busy <= '0;
    else
      r_busy <= w_nxt;
  end

  assign busy_o = r_busy;
endmodule

// File: rtl/ysyx_22040895_regfile_mp.sv
// Multi-port integer register file with bypass.
// Ports: NRD reads, NWR writes, busy scoreboard.
module ysyx_22040895_regfile_mp
  import ysyx_22040895_regfile_mp_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREG   = RF_NREG,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = RF_NRD,
  parameter int NWR    = RF_NWR,
  parameter int BYPASS = RF_BYP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD-1:0]      re_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rrdy_o,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic              alloc_i,
  input  logic [AW-1:0]     alloc_addr_i,
  input  logic              flush_i,
  output logic [NREG-1:0]   busy_o
);
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_busy;
  logic [AW-1:0]   w_ra;

  ysyx_22040895_rf_scoreboard #(
    .NREG(NREG),
    .AW  (AW),
    .NWR (NWR)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .alloc_i     (alloc_i),
    .alloc_addr_i(alloc_addr_i),
    .flush_i     (flush_i),
    .busy_o      (w_busy)
  );

  // ascending loop: the highest port index lands last
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACT) begin
      for (int r = 0; r < NREG; r++)
        r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we_i[j] == WR_EN &&
            waddr_i[j*AW +: AW] != '0)
          r_regs[waddr_i[j*AW +: AW]] <=
            wdata_i[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    rrdy_o  = '1;
    w_ra    = '0;
    if (rst != RST_ACT) begin
      for (int k = 0; k < NRD; k++) begin
        w_ra = raddr_i[k*AW +: AW];
        if (re_i[k] == RD_EN && w_ra != '0) begin
          rdata_o[k*XLEN +: XLEN] = r_regs[w_ra];
          rrdy_o[k] = ~w_busy[w_ra];
          if (BYPASS != 0) begin
            for (int j = 0; j < NWR; j++) begin
              if (we_i[j] == WR_EN &&
                  waddr_i[j*AW +: AW] == w_ra) begin
                rdata_o[k*XLEN +: XLEN] =
                  wdata_i[j*XLEN +: XLEN];
                rrdy_o[k] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign busy_o = w_busy;
endmodule

// File: tb/tb_ysyx_22040895_regfile_mp.sv
// Scoreboard bench for the multi-port regfile.
// Two instances: bypass on and bypass off.
module tb_ysyx_22040895_regfile_mp;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   re;
  logic [9:0]   raddr;
  logic [127:0] rdata, rdata_nb;
  logic [1:0]   rrdy, rrdy_nb;
  logic [1:0]   we;
  logic [9:0]   waddr;
  logic [127:0] wdata;
  logic         alloc;
  logic [4:0]   alloc_addr;
  logic         flush;
  logic [31:0]  busy, busy_nb;

  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] data;
    logic        rdy;
    logic [31:0] bv;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ysyx_22040895_regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .re_i(re), .raddr_i(raddr),
    .rdata_o(rdata), .rrdy_o(rrdy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .flush_i(flush), .busy_o(busy)
  );

  ysyx_22040895_regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .re_i(re), .raddr_i(raddr),
    .rdata_o(rdata_nb), .rrdy_o(rrdy_nb),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .flush_i(flush), .busy_o(busy_nb)
  );

  initial begin
    exp_t e;
    logic [63:0] d;
    logic        r;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (e.kind == 1) begin
          if (busy !== e.bv) begin
            errors++;
            $display("FAIL %s: busy=%h want %h",
                     e.name, busy, e.bv);
          end
        end else begin
          d = (e.kind == 0) ?
              rdata[e.idx*64 +: 64] :
              rdata_nb[e.idx*64 +: 64];
          r = (e.kind == 0) ? rrdy[e.idx] :
              rrdy_nb[e.idx];
          if (d !== e.data || r !== e.rdy) begin
            errors++;
            $display("FAIL %s: p%0d data=%h rdy=%b want %h %b",
                     e.name, e.idx, d, r, e.data, e.rdy);
          end
        end
      end
    end
  end

  task automatic idle();
    re = '0; raddr = '0;
    we = '0; waddr = '0; wdata = '0;
    alloc = 1'b0; alloc_addr = '0;
    flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int p, input int a);
    re[p] = 1'b1;
    raddr[p*5 +: 5] = 5'(a);
  endtask

  task automatic wr(input int p, input int a,
                    input logic [63:0] v);
    we[p] = 1'b1;
    waddr[p*5 +: 5] = 5'(a);
    wdata[p*64 +: 64] = v;
  endtask

  task automatic ex(input int kind, input int p,
                    input logic [63:0] v,
                    input logic ok, input string n);
    exp_t e;
    e.kind = kind; e.idx = p; e.data = v;
    e.rdy = ok; e.bv = '0; e.name = n;
    q.push_back(e);
  endtask

  task automatic exb(input logic [31:0] v,
                     input string n);
    exp_t e;
    e.kind = 1; e.idx = 0; e.data = '0;
    e.rdy = 1'b0; e.bv = v; e.name = n;
    q.push_back(e);
  endtask

  initial begin
    int n;
    idle();
    rd(0, 5); rd(1, 6);
    #2;
    ex(0, 0, 0, 1, "in_rst_p0");
    ex(0, 1, 0, 1, "in_rst_p1");
    exb(0, "in_rst_busy");
    @(negedge clk);
    #1 rst = 1'b1;

    for (int a = 1; a < 32; a++) begin
      step();
      rd(0, a); rd(1, 32 - a);
      ex(0, 0, 0, 1, "rst_rd_p0");
      ex(0, 1, 0, 1, "rst_rd_p1");
      if (a == 1) exb(0, "rst_busy");
    end

    step();
    wr(0, 5, 64'hDEAD_BEEF); rd(0, 5);
    ex(0, 0, 64'hDEAD_BEEF, 1, "byp_same");
    ex(2, 0, 0, 1, "nb_same");
    step();
    rd(1, 5);
    ex(0, 1, 64'hDEAD_BEEF, 1, "byp_next");
    ex(2, 1, 64'hDEAD_BEEF, 1, "nb_next");

    step();
    wr(0, 7, 64'h11); wr(1, 7, 64'h22); rd(0, 7);
    ex(0, 0, 64'h22, 1, "conf_byp");
    ex(2, 0, 0, 1, "conf_nb");
    step();
    rd(0, 7); rd(1, 7);
    ex(0, 0, 64'h22, 1, "conf_p0");
    ex(2, 1, 64'h22, 1, "conf_nb_p1");
    step();
    wr(0, 0, 64'hFF); rd(0, 0);
    ex(0, 0, 0, 1, "x0_same");
    step();
    rd(1, 0);
    ex(0, 1, 0, 1, "x0_next");

    step();
    alloc = 1'b1; alloc_addr = 5'd0;
    step();
    exb(0, "alloc_x0");
    alloc = 1'b1; alloc_addr = 5'd9; rd(0, 9);
    ex(0, 0, 0, 1, "alloc_same");
    step();
    rd(0, 9);
    exb(32'h200, "busy9");
    ex(0, 0, 0, 0, "busy9_rd");
    ex(2, 0, 0, 0, "busy9_nb");
    step();
    wr(0, 9, 64'h5); rd(0, 9);
    ex(0, 0, 64'h5, 1, "wb_byp");
    ex(2, 0, 0, 0, "wb_nb");
    step();
    rd(0, 9);
    exb(0, "busy_clr");
    ex(0, 0, 64'h5, 1, "wb_next");
    ex(2, 0, 64'h5, 1, "wb_nb_next");
    step();
    alloc = 1'b1; alloc_addr = 5'd9;
    wr(1, 9, 64'h6);
    step();
    rd(1, 9);
    exb(32'h200, "alloc_wins");
    ex(0, 1, 64'h6, 0, "alloc_wins_rd");

    step();
    alloc = 1'b1; alloc_addr = 5'd3;
    step();
    alloc = 1'b1; alloc_addr = 5'd4;
    step();
    flush = 1'b1;
    alloc = 1'b1; alloc_addr = 5'd6;
    wr(0, 3, 64'h77); rd(0, 3);
    exb(32'h218, "pre_flush");
    ex(0, 0, 64'h77, 1, "flush_byp");
    step();
    rd(0, 3); rd(1, 6);
    exb(0, "post_flush");
    ex(0, 0, 64'h77, 1, "flush_x3");
    ex(0, 1, 0, 1, "flush_x6");

    step();
    wr(0, 2, 64'hAB);
    alloc = 1'b1; alloc_addr = 5'd8;
    step();
    rd(0, 2);
    exb(32'h100, "busy8");
    ex(0, 0, 64'hAB, 1, "x2_val");
    step();
    wr(0, 2, 64'hCD); rd(0, 2);
    #1 rst = 1'b0;
    ex(0, 0, 0, 1, "arst_rd");
    ex(0, 1, 0, 1, "arst_p1");
    exb(0, "arst_busy");
    @(posedge clk);
    #1;
    ex(0, 0, 0, 1, "arst_hold");
    exb(0, "arst_hold_busy");
    @(negedge clk);
    #1;
    idle();
    rst = 1'b1;
    step();
    rd(0, 2); rd(1, 8);
    ex(0, 0, 0, 1, "arst_x2");
    ex(0, 1, 0, 1, "arst_x8");
    exb(0, "arst_busy2");

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: left=%0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
